// File: rtl/dtw_mem_responder.sv
// Word memory behind the DTW co-processor CS/WR/addr/Data bus, plus a host port
// that loads templates and reads results only while the co-processor bus is idle.
module dtw_mem_responder #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int DEPTH_LOG2 = 6,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  CS_i,
  input  logic                  WR_i,
  input  logic [ADDR_W-1:0]     addr_i,
  inout  wire  [DATA_W-1:0]     Data,
  input  logic                  host_req_i,
  input  logic                  host_we_i,
  input  logic [DEPTH_LOG2-1:0] host_addr_i,
  input  logic [DATA_W-1:0]     host_wdata_i,
  output logic [DATA_W-1:0]     host_rdata_o,
  output logic                  host_ack_o,
  output logic                  addr_err_o,
  output logic [CNT_W-1:0]      rd_cnt_o,
  output logic [CNT_W-1:0]      wr_cnt_o
);

  localparam int               DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, ACK} host_state_t;

  host_state_t           host_state;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DATA_W-1:0]     rd_q;
  logic [DEPTH_LOG2-1:0] cp_index;
  logic                  cp_read;
  logic                  cp_write;
  logic                  cp_alias;
  logic                  host_go;

  assign cp_index = addr_i[DEPTH_LOG2-1:0];
  assign cp_read  = !CS_i && !WR_i;
  assign cp_write = !CS_i && WR_i;
  assign cp_alias = |addr_i[ADDR_W-1:DEPTH_LOG2];
  // The host only proceeds on an idle bus, so it never collides with a co-processor write.
  assign host_go  = (host_state == IDLE) && host_req_i && CS_i;

  assign Data = cp_read ? rd_q : 'z;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if (cp_write) begin
        mem[cp_index] <= Data;
      end else if (host_go && host_we_i) begin
        mem[host_addr_i] <= host_wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rd_q       <= '0;
      addr_err_o <= 1'b0;
      rd_cnt_o   <= '0;
      wr_cnt_o   <= '0;
    end else begin
      if (cp_read) begin
        rd_q <= mem[cp_index];
      end
      if (!CS_i && cp_alias) begin
        addr_err_o <= 1'b1;
      end
      if (cp_read && (rd_cnt_o != CNT_MAX)) begin
        rd_cnt_o <= rd_cnt_o + CNT_W'(1);
      end
      if (cp_write && (wr_cnt_o != CNT_MAX)) begin
        wr_cnt_o <= wr_cnt_o + CNT_W'(1);
      end
    end
  end

  // ACK never re-executes, so a request still held during the ack pulse is served once.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      host_state   <= IDLE;
      host_ack_o   <= 1'b0;
      host_rdata_o <= '0;
    end else begin
      case (host_state)
        IDLE: begin
          if (host_go) begin
            host_state <= ACK;
            host_ack_o <= 1'b1;
            if (!host_we_i) begin
              host_rdata_o <= mem[host_addr_i];
            end
          end
        end
        ACK: begin
          host_state <= IDLE;
          host_ack_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtw_mem_responder.sv
// Randomized scoreboard bench for dtw_mem_responder: a word-array model predicts
// co-processor read data and host read data, monitors pop and compare on DUT outputs.
module tb_dtw_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs_n;
  logic        wr_en;
  logic [9:0]  addr;
  logic        drv_en;
  logic [31:0] drv_val;
  wire  [31:0] data_bus;
  logic        host_req;
  logic        host_we;
  logic [5:0]  host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic        host_ack;
  logic        addr_err;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] mem_model [64];
  logic [31:0] last_host_rdata;
  int          rd_model;
  int          wr_model;
  bit          err_model;
  logic [31:0] cp_q[$];
  logic [31:0] host_q[$];
  bit          prev_read = 1'b0;
  logic [31:0] exp_word;
  logic [31:0] exp_host;
  int          op;

  assign data_bus = drv_en ? drv_val : 'z;

  always #5 clk = ~clk;

  dtw_mem_responder dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .CS_i        (cs_n),
    .WR_i        (wr_en),
    .addr_i      (addr),
    .Data        (data_bus),
    .host_req_i  (host_req),
    .host_we_i   (host_we),
    .host_addr_i (host_addr),
    .host_wdata_i(host_wdata),
    .host_rdata_o(host_rdata),
    .host_ack_o  (host_ack),
    .addr_err_o  (addr_err),
    .rd_cnt_o    (rd_cnt),
    .wr_cnt_o    (wr_cnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // One co-processor bus cycle; the model learns what each access means at issue time.
  task automatic applyStimulus(input logic cs_val, input logic wr_val, input logic [9:0] a, input logic [31:0] wdata);
    @(posedge clk);
    #1;
    cs_n    = cs_val;
    wr_en   = wr_val;
    addr    = a;
    drv_en  = !cs_val && wr_val;
    drv_val = wdata;
    if (!cs_val && rst_n) begin
      if (a[9:6] != 4'd0) err_model = 1'b1;
      if (wr_val) begin
        mem_model[a[5:0]] = wdata;
        if (wr_model < 65535) wr_model++;
      end else begin
        cp_q.push_back(mem_model[a[5:0]]);
        if (rd_model < 65535) rd_model++;
      end
    end
  endtask

  task automatic hostAccess(input logic we, input logic [5:0] ha, input logic [31:0] wdata);
    int waited;
    bit seen;
    applyStimulus(1'b1, 1'b0, 10'd0, 32'd0);
    if (we) begin
      host_q.push_back(last_host_rdata);
      mem_model[ha] = wdata;
    end else begin
      last_host_rdata = mem_model[ha];
      host_q.push_back(last_host_rdata);
    end
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = ha;
    host_wdata = wdata;
    waited = 0;
    seen   = 1'b0;
    while (!seen && waited < 20) begin
      @(negedge clk);
      if (host_ack) seen = 1'b1;
      else waited++;
    end
    host_req = 1'b0;
    checkOutput("host_ack_latency", 32'(waited), 32'd1);
    @(negedge clk);
    checkOutput("host_ack_width", 32'(host_ack), 32'd0);
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_rd_cnt"}, 32'(rd_cnt), 32'(rd_model));
    checkOutput({tag, "_wr_cnt"}, 32'(wr_cnt), 32'(wr_model));
  endtask

  initial begin : cp_monitor
    forever begin
      @(negedge clk);
      if (prev_read) begin
        if (cp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL cp_read_queue: got a read with no expected word, expected a queued word");
        end else begin
          exp_word = cp_q.pop_front();
          if (!cs_n && !wr_en) checkOutput("cp_read_data", data_bus, exp_word);
        end
      end
      prev_read = rst_n && !cs_n && !wr_en;
    end
  end

  initial begin : host_monitor
    forever begin
      @(negedge clk);
      if (host_ack) begin
        if (host_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL host_unexpected_ack: got ack=1, expected ack=0");
        end else begin
          exp_host = host_q.pop_front();
          checkOutput("host_rdata", host_rdata, exp_host);
        end
      end
    end
  end

  initial begin : watchdog
    #(10 * 95000);
    $display("[TB] FAIL watchdog: got no finish, expected finish within 95000 cycles");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    rst_n = 1'b0; cs_n = 1'b1; wr_en = 1'b0; addr = '0; drv_en = 1'b0; drv_val = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    rd_model = 0; wr_model = 0; err_model = 1'b0; last_host_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_ack", 32'(host_ack), 32'd0);
    checkOutput("reset_rdata", host_rdata, 32'd0);
    checkOutput("reset_err", 32'(addr_err), 32'd0);
    checkCounters("reset");

    // Load every word so all later reads are predictable.
    for (int i = 0; i < 64; i++) begin
      hostAccess(1'b1, 6'(i), (i == 3) ? 32'h0080_2008 : {2'b00, 30'($urandom)});
    end

    applyStimulus(1'b0, 1'b0, 10'd3, '0);
    applyStimulus(1'b0, 1'b0, 10'd3, '0);
    applyStimulus(1'b0, 1'b0, 10'd4, '0);
    applyStimulus(1'b1, 1'b0, 10'd0, '0);

    applyStimulus(1'b0, 1'b1, 10'd20, 32'h0BEE_F123);
    applyStimulus(1'b0, 1'b0, 10'd20, '0);
    applyStimulus(1'b0, 1'b0, 10'd21, '0);
    hostAccess(1'b0, 6'd20, '0);

    // Host request held while the co-processor keeps the bus for three cycles.
    last_host_rdata = mem_model[9];
    host_q.push_back(last_host_rdata);
    applyStimulus(1'b0, 1'b0, 10'd1, '0);
    host_req = 1'b1; host_we = 1'b0; host_addr = 6'd9; host_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) applyStimulus(1'b0, 1'b0, 10'(i + 1), '0);
      @(negedge clk);
      checkOutput("starve_no_ack", 32'(host_ack), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 10'd0, '0);
    @(negedge clk);
    checkOutput("starve_no_ack", 32'(host_ack), 32'd0);
    @(negedge clk);
    checkOutput("starve_ack", 32'(host_ack), 32'd1);
    host_req = 1'b0;
    @(negedge clk);
    checkOutput("starve_ack_once", 32'(host_ack), 32'd0);

    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 9);
      if (op < 4) applyStimulus(1'b0, 1'b0, 10'($urandom_range(0, 63)), '0);
      else if (op < 7) applyStimulus(1'b0, 1'b1, 10'($urandom_range(0, 63)), {2'b00, 30'($urandom)});
      else if (op == 7) applyStimulus(1'b1, 1'b0, 10'd0, '0);
      else hostAccess(op[0], 6'($urandom_range(0, 63)), {2'b00, 30'($urandom)});
    end
    applyStimulus(1'b1, 1'b0, 10'd0, '0);
    @(negedge clk);
    checkCounters("random");
    checkOutput("err_before_alias", 32'(addr_err), 32'(err_model));

    applyStimulus(1'b0, 1'b0, 10'h045, '0);
    applyStimulus(1'b0, 1'b0, 10'h005, '0);
    applyStimulus(1'b1, 1'b0, 10'd0, '0);
    @(negedge clk);
    checkOutput("err_alias_set", 32'(addr_err), 32'd1);
    repeat (5) applyStimulus(1'b0, 1'b0, 10'($urandom_range(0, 63)), '0);
    applyStimulus(1'b1, 1'b0, 10'd0, '0);
    @(negedge clk);
    checkOutput("err_sticky", 32'(addr_err), 32'd1);

    // Reset lands on the same edge as an idle-bus host write to word 7.
    @(posedge clk);
    #1;
    rst_n = 1'b0; host_req = 1'b1; host_we = 1'b1; host_addr = 6'd7; host_wdata = ~mem_model[7];
    @(posedge clk);
    #1;
    rst_n = 1'b1; host_req = 1'b0;
    rd_model = 0; wr_model = 0; err_model = 1'b0; last_host_rdata = '0;
    @(negedge clk);
    checkOutput("rst_collide_ack", 32'(host_ack), 32'd0);
    checkOutput("rst_collide_rdata", host_rdata, 32'd0);
    checkOutput("rst_collide_err", 32'(addr_err), 32'd0);
    checkCounters("rst_collide");
    @(negedge clk);
    checkOutput("rst_collide_ack2", 32'(host_ack), 32'd0);
    hostAccess(1'b0, 6'd7, '0);

    for (int n = 0; n < 65540; n++) begin
      applyStimulus(1'b0, 1'b0, 10'($urandom_range(0, 63)), '0);
    end
    applyStimulus(1'b1, 1'b0, 10'd0, '0);
    @(negedge clk);
    checkOutput("rd_cnt_saturated", 32'(rd_cnt), 32'h0000_FFFF);
    checkOutput("wr_cnt_after_reads", 32'(wr_cnt), 32'd0);
    repeat (10) applyStimulus(1'b0, 1'b0, 10'($urandom_range(0, 63)), '0);
    applyStimulus(1'b0, 1'b1, 10'd30, {2'b00, 30'($urandom)});
    applyStimulus(1'b0, 1'b1, 10'd31, {2'b00, 30'($urandom)});
    applyStimulus(1'b0, 1'b0, 10'd30, '0);
    applyStimulus(1'b0, 1'b0, 10'd31, '0);
    applyStimulus(1'b1, 1'b0, 10'd0, '0);
    @(negedge clk);
    checkOutput("rd_cnt_holds", 32'(rd_cnt), 32'h0000_FFFF);
    checkCounters("final");

    repeat (3) applyStimulus(1'b1, 1'b0, 10'd0, '0);
    @(negedge clk);
    checkOutput("cp_queue_drained", 32'(cp_q.size()), 32'd0);
    checkOutput("host_queue_drained", 32'(host_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
